ndp_result_drain: RTL and testbench

NDP_RESULT_DRAIN -- requirements
Module: ndp_result_drain

---
 rtl/ndp_pkg.sv | 30 +++
 rtl/ndp_rise_detect.sv | 23 ++
 rtl/ndp_result_drain.sv | 123 ++++++++++++
 tb/tb_ndp_result_drain.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ndp_pkg.sv
// Shared definitions for the NDP result drain: FSM state encoding and the
// helpers that derive matrix geometry and counter widths from the parameters.
package ndp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Total result rows R across all vertically stacked arrays
    function automatic int calc_rows(input int arr_height, input int sys_height);
        return arr_height * sys_height;
    endfunction

    // Total result columns C across all horizontally tiled arrays
    function automatic int calc_cols(input int arr_width, input int sys_width);
        return arr_width * sys_width;
    endfunction

    // Output beats needed to carry one full row
    function automatic int calc_beats_per_row(input int cols, input int out_elems);
        return cols / out_elems;
    endfunction

    // Counter width for n distinct values, never narrower than one bit
    function automatic int counter_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ndp_rise_detect.sv
// Registered rising-edge detector for the NDP done level. The previous-value
// register clears on reset, so a flag already high after reset counts as a rise.
module ndp_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic flag,
    output logic rise
);

    logic flag_prev;

    // Remember last cycle's flag so a held-high level produces a single rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_prev <= 1'b0;
        end else begin
            flag_prev <= flag;
        end
    end

    assign rise = flag && !flag_prev;

endmodule

// File: rtl/ndp_result_drain.sv
// Captures a full systolic result matrix on a done-flag rise and streams it
// out row by row, OUT_ELEMS elements per beat, under valid/ready flow control.
module ndp_result_drain
    import ndp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ARR_WIDTH  = 4,
    parameter int ARR_HEIGHT = 4,
    parameter int SYS_WIDTH  = 64,
    parameter int SYS_HEIGHT = 1,
    parameter int OUT_ELEMS  = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   calc_done_flag,
    input  logic [calc_rows(ARR_HEIGHT, SYS_HEIGHT)
                 * calc_cols(ARR_WIDTH, SYS_WIDTH)
                 * WIDTH-1:0]                      in_c,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OUT_ELEMS*WIDTH-1:0]             out_data,
    output logic [counter_width(calc_rows(ARR_HEIGHT, SYS_HEIGHT))-1:0] out_row,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   drain_done,
    output logic                                   overflow
);

    localparam int ROWS   = calc_rows(ARR_HEIGHT, SYS_HEIGHT);
    localparam int COLS   = calc_cols(ARR_WIDTH, SYS_WIDTH);
    localparam int BPR    = calc_beats_per_row(COLS, OUT_ELEMS);
    localparam int ROW_W  = counter_width(ROWS);
    localparam int BEAT_W = counter_width(BPR);
    localparam int CAP_W  = ROWS * COLS * WIDTH;

    drain_state_e       state;
    logic [ROW_W-1:0]   row;
    logic [BEAT_W-1:0]  beat;
    logic [CAP_W-1:0]   cap;
    logic               rise;
    logic               fire;
    logic               row_end;
    logic               at_last;
    logic               capture;

    ndp_rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .flag  (calc_done_flag),
        .rise  (rise)
    );

    assign row_end   = (beat == BEAT_W'(BPR - 1));
    assign at_last   = row_end && (row == ROW_W'(ROWS - 1));
    assign out_valid = (state == DRAIN);
    assign busy      = (state == DRAIN);
    assign out_last  = out_valid && at_last;
    assign out_row   = row;
    assign fire      = out_valid && out_ready;
    // A rise is accepted when idle, or when it lands on the final handshake
    assign capture   = rise && ((state == IDLE) || (fire && at_last));

    // Capture register has no reset; its content only matters while draining
    always_ff @(posedge clk) begin
        if (capture) begin
            cap <= in_c;
        end
    end

    // Drain FSM: walks beats then rows, reports completion and dropped captures
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            row        <= '0;
            beat       <= '0;
            drain_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        row   <= '0;
                        beat  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rise && !(fire && at_last)) begin
                        overflow <= 1'b1;
                    end
                    if (fire) begin
                        if (at_last) begin
                            drain_done <= 1'b1;
                            row        <= '0;
                            beat       <= '0;
                            state      <= rise ? DRAIN : IDLE;
                        end else if (row_end) begin
                            beat <= '0;
                            row  <= row + ROW_W'(1);
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Select the current beat's element slice out of the captured matrix
    always_comb begin
        out_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int b = 0; b < BPR; b++) begin
                if (row == ROW_W'(r) && beat == BEAT_W'(b)) begin
                    out_data = cap[(r*COLS + b*OUT_ELEMS)*WIDTH +: OUT_ELEMS*WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_ndp_result_drain.sv
// Scoreboard bench for ndp_result_drain: directed drains push expected beats,
// an independent negedge monitor pops and compares every presented beat.
module tb_ndp_result_drain;

    localparam int W     = 8;
    localparam int NR    = 4;
    localparam int NC    = 8;
    localparam int NOE   = 4;
    localparam int NBPR  = NC / NOE;

    typedef struct {
        logic [NOE*W-1:0] data;
        logic [1:0]       row;
        logic             last;
    } beat_t;

    logic                 clk;
    logic                 reset;
    logic                 calc_done_flag;
    logic [NR*NC*W-1:0]   in_c;
    logic                 out_valid;
    logic                 out_ready;
    logic [NOE*W-1:0]     out_data;
    logic [1:0]           out_row;
    logic                 out_last;
    logic                 busy;
    logic                 drain_done;
    logic                 overflow;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  expect_done = 1'b0;

    ndp_result_drain #(
        .WIDTH      (8),
        .ARR_WIDTH  (4),
        .ARR_HEIGHT (4),
        .SYS_WIDTH  (2),
        .SYS_HEIGHT (1),
        .OUT_ELEMS  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .calc_done_flag (calc_done_flag),
        .in_c           (in_c),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_row        (out_row),
        .out_last       (out_last),
        .busy           (busy),
        .drain_done     (drain_done),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value against its expectation and tally the result
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Element value for pattern 0 (16*r+c) or pattern 1 (all 0xAA)
    function automatic logic [7:0] elem(input int mode, input int r, input int c);
        return (mode == 1) ? 8'hAA : 8'(16*r + c);
    endfunction

    // Drive in_c with a pattern, raise the flag and queue the expected beats
    task automatic apply_stimulus(input int mode);
        beat_t bt;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                in_c[(r*NC + c)*W +: W] = elem(mode, r, c);
        calc_done_flag = 1'b1;
        for (int r = 0; r < NR; r++) begin
            for (int b = 0; b < NBPR; b++) begin
                for (int k = 0; k < NOE; k++)
                    bt.data[k*W +: W] = elem(mode, r, b*NOE + k);
                bt.row  = 2'(r);
                bt.last = (r == NR-1) && (b == NBPR-1);
                exp_q.push_back(bt);
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the scoreboard to empty; returns cycles spent
    task automatic wait_drain(output int cyc);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d beats pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare presented beats against the queue head, pop on handshake
    always @(negedge clk) begin
        if (!reset) begin
            expect_done = 1'b0;
        end else begin
            check_output("drain_done", {63'd0, drain_done}, {63'd0, expect_done});
            expect_done = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got row %0d data 0x%0h required no beat", out_row, out_data);
                end else begin
                    check_output("beat_data", {32'd0, out_data}, {32'd0, exp_q[0].data});
                    check_output("beat_row",  {62'd0, out_row},  {62'd0, exp_q[0].row});
                    check_output("beat_last", {63'd0, out_last}, {63'd0, exp_q[0].last});
                    if (out_ready) begin
                        if (exp_q[0].last) expect_done = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        int pat [4] = '{1, 0, 0, 1};
        reset          = 1'b0;
        calc_done_flag = 1'b0;
        out_ready      = 1'b0;
        in_c           = '0;

        // Reset state
        #12;
        check_output("rst_valid",    {63'd0, out_valid},  64'd0);
        check_output("rst_busy",     {63'd0, busy},       64'd0);
        check_output("rst_last",     {63'd0, out_last},   64'd0);
        check_output("rst_done",     {63'd0, drain_done}, 64'd0);
        check_output("rst_overflow", {63'd0, overflow},   64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_cycles(2);

        // Basic drain with ready held high: 8 back-to-back beats
        $display("[TB] basic drain");
        out_ready = 1'b1;
        apply_stimulus(0);
        wait_cycles(1);
        calc_done_flag = 1'b0;
        check_output("busy_after_capture", {63'd0, busy}, 64'd1);
        wait_drain(cyc);
        check_output("drain_latency", 64'(cyc + 1), 64'd9);
        wait_cycles(3);
        check_output("idle_after_drain", {63'd0, busy}, 64'd0);

        // Backpressure: ready pattern 1,0,0,1
        $display("[TB] backpressure");
        out_ready = 1'b1;
        apply_stimulus(0);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) calc_done_flag = 1'b0;
            out_ready = pat[cyc % 4][0];
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL backpressure_timeout: got %0d beats pending required 0", exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b1;
        wait_cycles(3);

        // Back-to-back: new rise on the final handshake
        $display("[TB] back-to-back");
        apply_stimulus(0);
        wait_cycles(1);
        calc_done_flag = 1'b0;
        wait_cycles(7);
        apply_stimulus(1);
        wait_cycles(1);
        calc_done_flag = 1'b0;
        check_output("b2b_busy", {63'd0, busy}, 64'd1);
        wait_drain(cyc);
        wait_cycles(3);
        check_output("b2b_overflow", {63'd0, overflow}, 64'd0);

        // Overflow: second rise while beat 3 is presented
        $display("[TB] overflow");
        apply_stimulus(0);
        wait_cycles(1);
        calc_done_flag = 1'b0;
        wait_cycles(3);
        for (int i = 0; i < NR*NC; i++) in_c[i*W +: W] = 8'hAA;
        calc_done_flag = 1'b1;
        wait_cycles(1);
        calc_done_flag = 1'b0;
        check_output("overflow_set", {63'd0, overflow}, 64'd1);
        wait_drain(cyc);
        wait_cycles(5);
        check_output("overflow_sticky", {63'd0, overflow}, 64'd1);
        check_output("overflow_idle",   {63'd0, busy},     64'd0);

        // Reset in the middle of beat 5
        $display("[TB] reset mid-drain");
        apply_stimulus(0);
        wait_cycles(1);
        calc_done_flag = 1'b0;
        wait_cycles(5);
        #2;
        reset = 1'b0;
        #1;
        check_output("midrst_valid",    {63'd0, out_valid}, 64'd0);
        check_output("midrst_busy",     {63'd0, busy},      64'd0);
        check_output("midrst_overflow", {63'd0, overflow},  64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_cycles(2);
        apply_stimulus(0);
        wait_cycles(1);
        calc_done_flag = 1'b0;
        wait_drain(cyc);
        wait_cycles(3);

        // Flag held high for 20 cycles: exactly one drain
        $display("[TB] held flag");
        apply_stimulus(0);
        wait_cycles(20);
        calc_done_flag = 1'b0;
        wait_cycles(10);
        check_output("held_pending", 64'(exp_q.size()), 64'd0);
        check_output("held_idle",    {63'd0, busy},      64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
